// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings and controller state enumeration.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        MERGE,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Lane datapath: extracts and extends the addressed byte/half of a word, and builds a merged word for sub-word stores.
// Purely combinational; no backpressure.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];

        ext = '0;
        case (size)
            SZ_B:    ext = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_H:    ext = {{16{~uns & half_sel[15]}}, half_sel};
            SZ_W:    ext = word;
            default: ext = '0;
        endcase

        merged = word;
        case (size)
            SZ_B: begin
                case (off)
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    2'd3:    merged[31:24] = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (off[1]) merged[31:16] = wdata[15:0];
                else        merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit with one outstanding request; sub-word stores are read-modify-write.
// Latency: 1 cycle errors, 2 cycles loads/word stores, 3 cycles sub-word stores; req_ready only in IDLE.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int BADDR_W = ADDR_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [BADDR_W-1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [31:0]        mem_din,
    input  logic [31:0]        mem_dout
);

    lsu_state_e         state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [BADDR_W-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               req_bad;
    logic [31:0]        lane_ext;
    logic [31:0]        lane_merged;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_bad = (req_size == 2'b11)
               || (req_size == SZ_H && req_addr[0])
               || (req_size == SZ_W && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad)                          state_d = RESP;
                    else if (req_we && req_size == SZ_W)  state_d = WR;
                    else                                  state_d = RD;
                end
            end
            // Sub-word stores need the old word back before merging.
            RD:      state_d = we_q ? MERGE : RESP;
            WR:      state_d = RESP;
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane u_lane (
        .size   (size_q),
        .uns    (uns_q),
        .off    (addr_q[1:0]),
        .word   (mem_dout),
        .wdata  (wdata_q),
        .ext    (lane_ext),
        .merged (lane_merged)
    );

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? lane_ext : 32'h0;
        mem_addr  = addr_q[BADDR_W-1:2];
        mem_we    = (state_q == WR) || (state_q == MERGE);
        mem_din   = 32'h0;
        if (state_q == WR)         mem_din = wdata_q;
        else if (state_q == MERGE) mem_din = lane_merged;
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu against a synchronous read-before-write memory model.
module tb_lsu;

    localparam int ADDR_W  = 12;
    localparam int BADDR_W = ADDR_W + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_we = 1'b0;
    logic [1:0]         req_size = 2'b00;
    logic               req_unsigned = 1'b0;
    logic [BADDR_W-1:0] req_addr = '0;
    logic [31:0]        req_wdata = '0;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [31:0]        mem_din;
    logic [31:0]        mem_dout = '0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_dout <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    lsu #(.ADDR_W(ADDR_W), .BADDR_W(BADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where the next request may be driven.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [13:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_we);
        int          lat;
        int          we_cnt;
        logic        ready_leak;
        logic        got_err;
        logic [31:0] got_rdata;
        lat = 0; we_cnt = 0; ready_leak = 1'b0; got_err = 1'b0; got_rdata = '0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        chk({tag, ".ready_in"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (req_ready) ready_leak = 1'b1;
            if (rsp_valid) begin
                lat = k;
                got_err = rsp_err;
                got_rdata = rsp_rdata;
            end
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
        chk({tag, ".rdata"}, got_rdata, exp_rdata);
        chk({tag, ".we_cycles"}, we_cnt, exp_we);
        chk({tag, ".ready_busy"}, {31'b0, ready_leak}, 32'd0);
        @(negedge clk);
        chk({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
        chk({tag, ".no_extra_rsp"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic stray_rsp;
        @(negedge clk);
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst.mem_addr", {20'b0, mem_addr}, 32'd0);
        chk("rst.mem_din", mem_din, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req("sw_004", 1'b1, 2'b10, 1'b0, 14'h004, 32'h8899AABB, 2, 1'b0, 32'h0, 1);
        do_req("sw_008", 1'b1, 2'b10, 1'b0, 14'h008, 32'h11223344, 2, 1'b0, 32'h0, 1);
        do_req("sw_00c", 1'b1, 2'b10, 1'b0, 14'h00C, 32'hCAFEF00D, 2, 1'b0, 32'h0, 1);

        do_req("lb_006",  1'b0, 2'b00, 1'b0, 14'h006, 32'h0, 2, 1'b0, 32'hFFFFFF99, 0);
        do_req("lhu_006", 1'b0, 2'b01, 1'b1, 14'h006, 32'h0, 2, 1'b0, 32'h00008899, 0);
        do_req("lh_004",  1'b0, 2'b01, 1'b0, 14'h004, 32'h0, 2, 1'b0, 32'hFFFFAABB, 0);
        do_req("lbu_007", 1'b0, 2'b00, 1'b1, 14'h007, 32'h0, 2, 1'b0, 32'h00000088, 0);
        do_req("lw_004",  1'b0, 2'b10, 1'b0, 14'h004, 32'h0, 2, 1'b0, 32'h8899AABB, 0);

        do_req("sb_009", 1'b1, 2'b00, 1'b0, 14'h009, 32'h000000EE, 3, 1'b0, 32'h0, 1);
        do_req("lw_008a", 1'b0, 2'b10, 1'b0, 14'h008, 32'h0, 2, 1'b0, 32'h1122EE44, 0);
        do_req("sh_00a", 1'b1, 2'b01, 1'b0, 14'h00A, 32'hFFFF5566, 3, 1'b0, 32'h0, 1);
        do_req("lw_008b", 1'b0, 2'b10, 1'b0, 14'h008, 32'h0, 2, 1'b0, 32'h5566EE44, 0);
        do_req("lb_008", 1'b0, 2'b00, 1'b0, 14'h008, 32'h0, 2, 1'b0, 32'h00000044, 0);

        do_req("err_lw_00a", 1'b0, 2'b10, 1'b0, 14'h00A, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("err_sz11",   1'b0, 2'b11, 1'b0, 14'h004, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("err_lh_005", 1'b0, 2'b01, 1'b1, 14'h005, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("err_sw_006", 1'b1, 2'b10, 1'b0, 14'h006, 32'h12345678, 1, 1'b1, 32'h0, 0);
        do_req("lw_004_kept", 1'b0, 2'b10, 1'b0, 14'h004, 32'h0, 2, 1'b0, 32'h8899AABB, 0);

        // Reset while the half store at 0x00C sits in MERGE.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 14'h00C; req_wdata = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstm.in_merge_we", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstm.mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstm.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstm.ready", {31'b0, req_ready}, 32'd1);
        chk("rstm.mem_addr", {20'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) stray_rsp = 1'b1;
        end
        chk("rstm.no_rsp", {31'b0, stray_rsp}, 32'd0);
        do_req("lw_00c_kept", 1'b0, 2'b10, 1'b0, 14'h00C, 32'h0, 2, 1'b0, 32'hCAFEF00D, 0);

        do_req("b2b_sw_010", 1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        do_req("b2b_lw_010", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
